// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for the lab4 multi-cycle RV32I CPU.
// Steps each instruction through IF/ID/EX/MEM/WB, producing the holding
// register write enables, register-file write, memory requests and the
// datapath mux selects as Mealy outputs of state, opcode and status flags.
// Optional feature macro: MC_PERF_CNT_EN (retired-instruction counter on
// NUM_INST). Without it NUM_INST is tied to zero and no counter flops exist.
module multicycle_ctrl #(
   parameter int unsigned WAIT_MAX = 15,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [31:0]      INSTR,
   input  logic             I_MEM_RDY,
   input  logic             D_MEM_RDY,
   input  logic             BR_TAKEN,
   input  logic             HALT_REQ,
   output logic             PC_WREN,
   output logic             IR_WREN,
   output logic             AB_WREN,
   output logic             ALUOUT_WREN,
   output logic             MDR_WREN,
   output logic             RF_WE,
   output logic             I_MEM_REQ,
   output logic             D_MEM_REQ,
   output logic             D_MEM_WE,
   output logic [1:0]       ALU_SRC_A,
   output logic [1:0]       ALU_SRC_B,
   output logic [1:0]       PC_SRC,
   output logic [1:0]       WB_SEL,
   output logic [2:0]       STATE,
   output logic             HALT,
   output logic             ERR,
   output logic [CNT_W-1:0] NUM_INST
);

   // Wait counter must hold WAIT_MAX and is never narrower than 4 bits.
   localparam int unsigned WAIT_W = (WAIT_MAX < 32'd16) ? 4 : $clog2(WAIT_MAX + 1);
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(WAIT_MAX);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic              err_q, err_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [6:0]        opcode_s;
   logic              unused_instr_s;

   assign opcode_s       = INSTR[6:0];
   // Only the opcode field steers control; the rest of IR belongs to the datapath.
   assign unused_instr_s = ^INSTR[31:7];

   // Next-state, fault tracking and Mealy output decode; everything forced to 0 in reset.
   always_comb begin
      state_d     = state_q;
      err_d       = err_q;
      wait_d      = {WAIT_W{1'b0}};
      PC_WREN     = 1'b0;
      IR_WREN     = 1'b0;
      AB_WREN     = 1'b0;
      ALUOUT_WREN = 1'b0;
      MDR_WREN    = 1'b0;
      RF_WE       = 1'b0;
      I_MEM_REQ   = 1'b0;
      D_MEM_REQ   = 1'b0;
      D_MEM_WE    = 1'b0;
      ALU_SRC_A   = 2'd0;
      ALU_SRC_B   = 2'd0;
      PC_SRC      = 2'd0;
      WB_SEL      = 2'd0;
      STATE       = 3'd0;
      HALT        = 1'b0;
      ERR         = 1'b0;
      if (RST) begin
         // Flops clear on the next edge; outputs stay quiet meanwhile.
         state_d = S_IF;
         err_d   = 1'b0;
      end else begin
         STATE = state_q;
         ERR   = err_q;
         case (state_q)
            S_IF: begin
               I_MEM_REQ = 1'b1;
               if (I_MEM_RDY) begin
                  IR_WREN = 1'b1;
                  state_d = S_ID;
               end else if (wait_q == WAIT_LIMIT) begin
                  state_d = S_HALT;
                  err_d   = 1'b1;
               end else begin
                  wait_d = wait_q + WAIT_W'(1);
               end
            end
            S_ID: begin
               AB_WREN = 1'b1;
               if (HALT_REQ) begin
                  state_d = S_HALT;
                  err_d   = 1'b0;
               end else begin
                  case (opcode_s)
                     OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                     OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP: state_d = S_EX;
                     default: begin
                        state_d = S_HALT;
                        err_d   = 1'b1;
                     end
                  endcase
               end
            end
            S_EX: begin
               ALUOUT_WREN = 1'b1;
               case (opcode_s)
                  OPC_LUI: begin
                     ALU_SRC_A = 2'd2;
                     ALU_SRC_B = 2'd1;
                     state_d   = S_WB;
                  end
                  OPC_AUIPC, OPC_JAL: begin
                     ALU_SRC_A = 2'd1;
                     ALU_SRC_B = 2'd1;
                     state_d   = S_WB;
                  end
                  OPC_JALR, OPC_OPIMM: begin
                     ALU_SRC_B = 2'd1;
                     state_d   = S_WB;
                  end
                  OPC_LOAD, OPC_STORE: begin
                     ALU_SRC_B = 2'd1;
                     state_d   = S_MEM;
                  end
                  OPC_OP: begin
                     state_d = S_WB;
                  end
                  OPC_BRANCH: begin
                     PC_WREN = 1'b1;
                     PC_SRC  = BR_TAKEN ? 2'd1 : 2'd0;
                     state_d = S_IF;
                  end
                  default: begin
                     // IR changed under us after decode: stop rather than guess.
                     state_d = S_HALT;
                     err_d   = 1'b1;
                  end
               endcase
            end
            S_MEM: begin
               D_MEM_REQ = 1'b1;
               D_MEM_WE  = (opcode_s == OPC_STORE);
               if (D_MEM_RDY) begin
                  if (opcode_s == OPC_STORE) begin
                     PC_WREN = 1'b1;
                     state_d = S_IF;
                  end else begin
                     MDR_WREN = 1'b1;
                     state_d  = S_WB;
                  end
               end else if (wait_q == WAIT_LIMIT) begin
                  state_d = S_HALT;
                  err_d   = 1'b1;
               end else begin
                  wait_d = wait_q + WAIT_W'(1);
               end
            end
            S_WB: begin
               RF_WE   = 1'b1;
               PC_WREN = 1'b1;
               state_d = S_IF;
               case (opcode_s)
                  OPC_LOAD: WB_SEL = 2'd1;
                  OPC_JAL: begin
                     WB_SEL = 2'd2;
                     PC_SRC = 2'd1;
                  end
                  OPC_JALR: begin
                     WB_SEL = 2'd2;
                     PC_SRC = 2'd2;
                  end
                  default: WB_SEL = 2'd0;
               endcase
            end
            S_HALT: begin
               HALT = 1'b1;
            end
            default: begin
               state_d = S_HALT;
               err_d   = 1'b1;
            end
         endcase
      end
   end

   // State, fault flag and wait counter registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IF;
         err_q   <= 1'b0;
         wait_q  <= {WAIT_W{1'b0}};
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         wait_q  <= wait_d;
      end
   end

`ifdef MC_PERF_CNT_EN
   logic [CNT_W-1:0] num_inst_q, num_inst_d;

   // Retired-instruction count: one per PC write, saturating at all-ones.
   always_comb begin
      num_inst_d = num_inst_q;
      if (PC_WREN && (num_inst_q != {CNT_W{1'b1}})) begin
         num_inst_d = num_inst_q + CNT_W'(1);
      end else begin
         num_inst_d = num_inst_q;
      end
   end

   // Retired-instruction counter register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         num_inst_q <= {CNT_W{1'b0}};
      end else begin
         num_inst_q <= num_inst_d;
      end
   end

   assign NUM_INST = RST ? {CNT_W{1'b0}} : num_inst_q;
`else
   assign NUM_INST = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table-driven directed bench for multicycle_ctrl plus
// hand-written sequences for wait timeout, halt, illegal opcode and reset.
module tb_multicycle_ctrl;

   localparam int unsigned CNT_W = 32;

   localparam logic [31:0] I_ADD   = 32'h002081B3;
   localparam logic [31:0] I_LW    = 32'h0000A183;
   localparam logic [31:0] I_BEQ   = 32'h00208463;
   localparam logic [31:0] I_JALR  = 32'h00008067;
   localparam logic [31:0] I_SW    = 32'h0020A023;
   localparam logic [31:0] I_LUI   = 32'h000000B7;
   localparam logic [31:0] I_JAL   = 32'h000000EF;
   localparam logic [31:0] I_AUIPC = 32'h00000097;
   localparam logic [31:0] I_ADDI  = 32'h00108093;
   localparam logic [31:0] I_ILL   = 32'h0000007F;

   // {PC,IR,AB,ALUOUT,MDR,RF, IREQ,DREQ,DWE, HALT,ERR}
   localparam logic [10:0] C_NONE = 11'b00000000000;
   localparam logic [10:0] C_IFW  = 11'b00000010000;
   localparam logic [10:0] C_IFR  = 11'b01000010000;
   localparam logic [10:0] C_ID   = 11'b00100000000;
   localparam logic [10:0] C_EX   = 11'b00010000000;
   localparam logic [10:0] C_EXBR = 11'b10010000000;
   localparam logic [10:0] C_WB   = 11'b10000100000;
   localparam logic [10:0] C_MW   = 11'b00000001000;
   localparam logic [10:0] C_ML   = 11'b00001001000;
   localparam logic [10:0] C_MS   = 11'b10000001100;

`ifdef MC_PERF_CNT_EN
   localparam logic [31:0] EXP_NUM = 32'd10;
`else
   localparam logic [31:0] EXP_NUM = 32'd0;
`endif

   logic             CLK = 1'b0;
   logic             RST = 1'b1;
   logic [31:0]      INSTR = 32'd0;
   logic             I_MEM_RDY = 1'b0, D_MEM_RDY = 1'b0, BR_TAKEN = 1'b0, HALT_REQ = 1'b0;
   logic             PC_WREN, IR_WREN, AB_WREN, ALUOUT_WREN, MDR_WREN, RF_WE;
   logic             I_MEM_REQ, D_MEM_REQ, D_MEM_WE, HALT, ERR;
   logic [1:0]       ALU_SRC_A, ALU_SRC_B, PC_SRC, WB_SEL;
   logic [2:0]       STATE;
   logic [CNT_W-1:0] NUM_INST;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        rst;
      logic [31:0] instr;
      logic        irdy, drdy, br, hreq;
      logic [2:0]  st;
      logic [10:0] ctl;
      logic [1:0]  a, b, pcs, wb;
   } vec_t;

   vec_t vecs[$];

   multicycle_ctrl #(.WAIT_MAX(15), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RST(RST), .INSTR(INSTR),
      .I_MEM_RDY(I_MEM_RDY), .D_MEM_RDY(D_MEM_RDY), .BR_TAKEN(BR_TAKEN), .HALT_REQ(HALT_REQ),
      .PC_WREN(PC_WREN), .IR_WREN(IR_WREN), .AB_WREN(AB_WREN), .ALUOUT_WREN(ALUOUT_WREN),
      .MDR_WREN(MDR_WREN), .RF_WE(RF_WE), .I_MEM_REQ(I_MEM_REQ), .D_MEM_REQ(D_MEM_REQ),
      .D_MEM_WE(D_MEM_WE), .ALU_SRC_A(ALU_SRC_A), .ALU_SRC_B(ALU_SRC_B), .PC_SRC(PC_SRC),
      .WB_SEL(WB_SEL), .STATE(STATE), .HALT(HALT), .ERR(ERR), .NUM_INST(NUM_INST)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Drive one cycle's inputs on the falling edge and let outputs settle.
   task automatic cyc(input logic r, input logic [31:0] ins, input logic ir, input logic dr,
                      input logic b, input logic h);
      @(negedge CLK);
      RST = r; INSTR = ins; I_MEM_RDY = ir; D_MEM_RDY = dr; BR_TAKEN = b; HALT_REQ = h;
      #2;
   endtask

   task automatic add(input logic r, input logic [31:0] ins, input logic ir, input logic dr,
                      input logic b, input logic h, input logic [2:0] st, input logic [10:0] ctl,
                      input logic [1:0] a, input logic [1:0] bb, input logic [1:0] pcs,
                      input logic [1:0] wb);
      vec_t v;
      v.rst = r; v.instr = ins; v.irdy = ir; v.drdy = dr; v.br = b; v.hreq = h;
      v.st = st; v.ctl = ctl; v.a = a; v.b = bb; v.pcs = pcs; v.wb = wb;
      vecs.push_back(v);
   endtask

   // IF with immediate RDY followed by ID.
   task automatic fetch(input logic [31:0] ins);
      add(1'b0, ins, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, C_IFR, 2'd0, 2'd0, 2'd0, 2'd0);
      add(1'b0, ins, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, C_ID,  2'd0, 2'd0, 2'd0, 2'd0);
   endtask

   function automatic logic [21:0] outs();
      return {STATE, PC_WREN, IR_WREN, AB_WREN, ALUOUT_WREN, MDR_WREN, RF_WE,
              I_MEM_REQ, D_MEM_REQ, D_MEM_WE, HALT, ERR, ALU_SRC_A, ALU_SRC_B, PC_SRC, WB_SEL};
   endfunction

   initial begin
      logic seen;
      // Reset, then ten mixed instructions.
      add(1'b1, I_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, C_NONE, 2'd0, 2'd0, 2'd0, 2'd0);
      fetch(I_ADD);
      add(1'b0, I_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, C_EX, 2'd0, 2'd0, 2'd0, 2'd0);
      add(1'b0, I_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, C_WB, 2'd0, 2'd0, 2'd0, 2'd0);
      for (int i = 0; i < 3; i++)
         add(1'b0, I_LW, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0, C_IFW, 2'd0, 2'd0, 2'd0, 2'd0);
      fetch(I_LW);
      add(1'b0, I_LW, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, C_EX, 2'd0, 2'd1, 2'd0, 2'd0);
      for (int i = 0; i < 2; i++)
         add(1'b0, I_LW, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3, C_MW, 2'd0, 2'd0, 2'd0, 2'd0);
      add(1'b0, I_LW, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, C_ML, 2'd0, 2'd0, 2'd0, 2'd0);
      add(1'b0, I_LW, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, C_WB, 2'd0, 2'd0, 2'd0, 2'd1);
      fetch(I_BEQ);
      add(1'b0, I_BEQ, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, C_EXBR, 2'd0, 2'd0, 2'd1, 2'd0);
      fetch(I_BEQ);
      add(1'b0, I_BEQ, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, C_EXBR, 2'd0, 2'd0, 2'd0, 2'd0);
      fetch(I_JALR);
      add(1'b0, I_JALR, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, C_EX, 2'd0, 2'd1, 2'd0, 2'd0);
      add(1'b0, I_JALR, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, C_WB, 2'd0, 2'd0, 2'd2, 2'd2);
      fetch(I_SW);
      add(1'b0, I_SW, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, C_EX, 2'd0, 2'd1, 2'd0, 2'd0);
      add(1'b0, I_SW, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, C_MS, 2'd0, 2'd0, 2'd0, 2'd0);
      fetch(I_LUI);
      add(1'b0, I_LUI, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, C_EX, 2'd2, 2'd1, 2'd0, 2'd0);
      add(1'b0, I_LUI, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, C_WB, 2'd0, 2'd0, 2'd0, 2'd0);
      fetch(I_JAL);
      add(1'b0, I_JAL, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, C_EX, 2'd1, 2'd1, 2'd0, 2'd0);
      add(1'b0, I_JAL, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, C_WB, 2'd0, 2'd0, 2'd1, 2'd2);
      fetch(I_AUIPC);
      add(1'b0, I_AUIPC, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, C_EX, 2'd1, 2'd1, 2'd0, 2'd0);
      add(1'b0, I_AUIPC, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, C_WB, 2'd0, 2'd0, 2'd0, 2'd0);
      fetch(I_ADDI);
      add(1'b0, I_ADDI, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, C_EX, 2'd0, 2'd1, 2'd0, 2'd0);
      add(1'b0, I_ADDI, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, C_WB, 2'd0, 2'd0, 2'd0, 2'd0);

      foreach (vecs[i]) begin
         cyc(vecs[i].rst, vecs[i].instr, vecs[i].irdy, vecs[i].drdy, vecs[i].br, vecs[i].hreq);
         chk($sformatf("vec%0d", i), {10'd0, outs()},
             {10'd0, vecs[i].st, vecs[i].ctl, vecs[i].a, vecs[i].b, vecs[i].pcs, vecs[i].wb});
      end
      cyc(1'b0, I_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("num_inst_10", NUM_INST, EXP_NUM);
      chk("back_in_if", {29'd0, STATE}, 32'd0);

      // RDY on the 16th IF cycle is still accepted.
      cyc(1'b1, I_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 15; i++) begin
         cyc(1'b0, I_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
         chk($sformatf("wait_req%0d", i), {31'd0, I_MEM_REQ}, 32'd1);
      end
      cyc(1'b0, I_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("rdy16_ir", {31'd0, IR_WREN}, 32'd1);
      cyc(1'b0, I_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rdy16_state", {29'd0, STATE}, 32'd1);
      chk("rdy16_err", {31'd0, ERR}, 32'd0);

      // RDY never arrives: fault after 16 IF cycles.
      cyc(1'b1, I_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 16; i++) begin
         cyc(1'b0, I_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
         seen = seen | IR_WREN | (STATE != 3'd0);
      end
      chk("tmo_in_if_16", {31'd0, seen}, 32'd0);
      cyc(1'b0, I_ADD, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("tmo_state", {29'd0, STATE}, 32'd5);
      chk("tmo_halt_err", {30'd0, HALT, ERR}, 32'd3);
      chk("tmo_quiet", {31'd0, I_MEM_REQ | IR_WREN | PC_WREN}, 32'd0);

      // Illegal opcode in ID.
      cyc(1'b1, I_ILL, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, I_ILL, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, I_ILL, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("ill_ab", {31'd0, AB_WREN}, 32'd1);
      cyc(1'b0, I_ILL, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("ill_state", {29'd0, STATE}, 32'd5);
      chk("ill_halt_err", {30'd0, HALT, ERR}, 32'd3);

      // Halt request in ID: clean halt, sticky until reset.
      cyc(1'b1, I_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, I_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, I_ADD, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, I_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("hreq_halt_err", {30'd0, HALT, ERR}, 32'd2);
      cyc(1'b0, I_ADD, 1'b1, 1'b1, 1'b1, 1'b1);
      chk("hreq_sticky", {10'd0, outs()}, {10'd0, 3'd5, 11'b00000000010, 8'd0});

      // Reset asserted during MEM aborts the load.
      cyc(1'b1, I_LW, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, I_LW, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, I_LW, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, I_LW, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, I_LW, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("mem_req", {29'd0, STATE}, 32'd3);
      cyc(1'b1, I_LW, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("rst_outs", {10'd0, outs()}, 32'd0);
      chk("rst_num", NUM_INST, 32'd0);
      cyc(1'b0, I_LW, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("post_rst", {10'd0, outs()}, {10'd0, 3'd0, C_IFW, 8'd0});
      chk("post_rst_num", NUM_INST, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
